// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fifo_write_arbiter_if                                  |
// | Brief   : Producer handshake + shared FIFO write-side bundle.    |
// | Option  : FIFO_ARB_SRCID_EN widens fifo_wdata by IDW bits        |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    localparam int IDW = $clog2(NREQ);
`ifdef FIFO_ARB_SRCID_EN
    localparam int WDW = DWIDTH + IDW;
`else
    localparam int WDW = DWIDTH;
`endif

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_w_en;
    logic [WDW-1:0]         fifo_wdata;
    logic                   fifo_wfull;
    logic                   grant_active;
    logic [IDW-1:0]         grant_id;

    // Arbiter side
    modport master (
        input  req_valid, req_last, req_data, fifo_wfull,
        output req_ready, fifo_w_en, fifo_wdata, grant_active, grant_id
    );

    // Producers + FIFO side
    modport slave (
        output req_valid, req_last, req_data, fifo_wfull,
        input  req_ready, fifo_w_en, fifo_wdata, grant_active, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fifo_write_arbiter                                     |
// | Brief   : Round-robin burst arbiter sharing one FIFO write port. |
// | Option  : FIFO_ARB_SRCID_EN -> fifo_wdata = {grant_id, data}     |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input wire                   clk,
    input wire                   rst,
    fifo_write_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0]        r_state;
    logic [IDW-1:0]    r_grant_id;
    logic [IDW-1:0]    r_last_grant;
    logic [BCW-1:0]    r_beat_cnt;

    logic              w_found;
    logic [IDW-1:0]    w_next_id;
    logic [IDW-1:0]    w_cand;
    logic              w_valid_g;
    logic              w_last_g;
    logic              w_xfer;
    logic              w_release;
    logic [DWIDTH-1:0] w_data_g;

    // Rotating search starting just after the last released grant
    always_comb begin
        w_found   = 1'b0;
        w_next_id = '0;
        w_cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_next_id = w_cand;
            end
        end
    end

    assign w_valid_g = bus.req_valid[r_grant_id];
    assign w_last_g  = bus.req_last[r_grant_id];
    assign w_data_g  = bus.req_data[r_grant_id*DWIDTH +: DWIDTH];

    // Reset suppresses any in-flight beat so a half-cycle burst never reaches the FIFO
    assign w_xfer    = (r_state == c_BURST) & w_valid_g & ~bus.fifo_wfull & ~rst;
    assign w_release = (w_xfer & (w_last_g | (r_beat_cnt == BCW'(MAX_BURST - 1))))
                     | ~w_valid_g;

    always_comb begin
        bus.req_ready = '0;
        if ((r_state == c_BURST) && !rst && !bus.fifo_wfull)
            bus.req_ready[r_grant_id] = 1'b1;
    end

    assign bus.fifo_w_en    = w_xfer;
`ifdef FIFO_ARB_SRCID_EN
    assign bus.fifo_wdata   = {r_grant_id, w_data_g};
`else
    assign bus.fifo_wdata   = w_data_g;
`endif
    assign bus.grant_active = (r_state == c_BURST);
    assign bus.grant_id     = r_grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_next_id;
                        r_beat_cnt <= '0;
                        r_state    <= c_BURST;
                    end
                end
                c_BURST: begin
                    if (w_xfer)
                        r_beat_cnt <= r_beat_cnt + BCW'(1);
                    if (w_release) begin
                        r_last_grant <= r_grant_id;
                        r_beat_cnt   <= '0;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_fifo_write_arbiter;
    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = $clog2(NREQ);
`ifdef FIFO_ARB_SRCID_EN
    localparam int WDW = DWIDTH + IDW;
`else
    localparam int WDW = DWIDTH;
`endif
    localparam int PW = NREQ + 1 + WDW + 1 + IDW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_write_arbiter #(
        .NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0]   en;
    logic [DWIDTH:0]   rq [NREQ][$];
    logic [WDW-1:0]    wlog [$];
    int                wsrc [$];
    int                gq   [$];

    // Model state: is a grant held, who holds it, who last released, beats written this grant
    int m_busy, m_gid, m_last, m_beats;

    function automatic logic [WDW-1:0] mkwd(input int s, input logic [DWIDTH-1:0] d);
`ifdef FIFO_ARB_SRCID_EN
        return {IDW'(s), d};
`else
        return d;
`endif
    endfunction

    function automatic logic [PW-1:0] exp_vec();
        logic [NREQ-1:0] rdy;
        logic            wen;
        logic [WDW-1:0]  wd;
        rdy = '0;
        wen = 1'b0;
        wd  = '0;
        if (!rst && m_busy != 0) begin
            if (!bus.fifo_wfull) rdy[m_gid] = 1'b1;
            wen = bus.req_valid[m_gid] && !bus.fifo_wfull;
        end
        if (wen) wd = mkwd(m_gid, bus.req_data[m_gid*DWIDTH +: DWIDTH]);
        return {rdy, wen, wd, (m_busy != 0), IDW'(m_gid)};
    endfunction

    function automatic logic [PW-1:0] obs_vec();
        return {bus.req_ready, bus.fifo_w_en,
                (bus.fifo_w_en ? bus.fifo_wdata : {WDW{1'b0}}),
                bus.grant_active, bus.grant_id};
    endfunction

    task automatic model_step();
        bit xfer;
        int c;
        if (rst) begin
            m_busy = 0; m_gid = 0; m_last = NREQ - 1; m_beats = 0;
        end else if (m_busy == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (m_busy == 0 && bus.req_valid[c]) begin
                    m_busy = 1; m_gid = c; m_beats = 0;
                end
            end
        end else begin
            xfer = bus.req_valid[m_gid] && !bus.fifo_wfull;
            if (xfer) m_beats++;
            if ((xfer && bus.req_last[m_gid]) || m_beats == MAX_BURST || !bus.req_valid[m_gid]) begin
                m_last = m_gid; m_busy = 0; m_beats = 0;
            end
        end
    endtask

    task automatic drive();
        logic [DWIDTH:0] h;
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && rq[i].size() > 0) begin
                h = rq[i][0];
                bus.req_valid[i] = 1'b1;
                bus.req_last[i]  = h[DWIDTH];
                bus.req_data[i*DWIDTH +: DWIDTH] = h[DWIDTH-1:0];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_last[i]  = 1'b0;
            end
        end
    endtask

    // Called at the sampling point; commits handshakes and moves to just after the next edge
    task automatic advance();
        if (!rst) begin
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i] && bus.req_valid[i] && rq[i].size() > 0)
                    rq[i].delete(0);
            if (bus.fifo_w_en) begin
                wlog.push_back(bus.fifo_wdata);
                wsrc.push_back(m_gid);
            end
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        wlog.delete();
        wsrc.delete();
        gq.delete();
        en = '0;
        bus.fifo_wfull = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin drive(); #4; advance(); end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear();
        en = '1;
        for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, DWIDTH'(i)});
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(); #4;
            checks++;
            if ({bus.req_ready, bus.fifo_w_en} !== '0) begin
                errors++;
                $display("FAIL reset_outputs_during obs=%b required=0", {bus.req_ready, bus.fifo_w_en});
            end
            advance();
        end
        rst = 1'b0;
        drive(); #4;
        checks++;
        if ({bus.grant_active, bus.grant_id, bus.req_ready, bus.fifo_w_en} !== '0) begin
            errors++;
            $display("FAIL reset_state_after obs=%b required=0",
                     {bus.grant_active, bus.grant_id, bus.req_ready, bus.fifo_w_en});
        end
        advance();
        drive(); #4;
        checks++;
        if (!(bus.grant_active === 1'b1 && bus.grant_id === IDW'(0))) begin
            errors++;
            $display("FAIL reset_first_grant active=%b id=%0d required active=1 id=0",
                     bus.grant_active, bus.grant_id);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic prev;
        clear(); do_reset();
        en = '1;
        for (int i = 0; i < NREQ; i++)
            repeat (8) rq[i].push_back({1'b0, DWIDTH'($urandom)});
        prev = 1'b0;
        for (int c = 0; c < 25; c++) begin
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            if (bus.grant_active && !prev) gq.push_back(int'(bus.grant_id));
            prev = bus.grant_active;
            advance();
        end
        checks++;
        if (gq.size() != 5 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3 || gq[4] != 0) begin
            errors++;
            $display("FAIL rr_grant_order got=%p required=0,1,2,3,0", gq);
        end
        checks++;
        if (wlog.size() != 20) begin
            errors++;
            $display("FAIL rr_write_count got=%0d required=20", wlog.size());
        end
    endtask

    task automatic test_last();
        clear(); do_reset();
        en = 4'b0100;
        rq[2].push_back({1'b0, 8'h10});
        rq[2].push_back({1'b1, 8'h11});
        for (int c = 0; c < 5; c++) begin
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL last_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                checks++;
                if (bus.grant_active !== 1'b0 || bus.req_ready[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL last_release active=%b ready2=%b required 0,0",
                             bus.grant_active, bus.req_ready[2]);
                end
            end
            advance();
        end
        checks++;
        if (wlog.size() != 2 || wlog[0] !== mkwd(2, 8'h10) || wlog[1] !== mkwd(2, 8'h11)) begin
            errors++;
            $display("FAIL last_data got=%p required=10,11", wlog);
        end
    endtask

    task automatic test_backpressure();
        logic [DWIDTH-1:0] d [4];
        clear(); do_reset();
        en = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            d[b] = DWIDTH'($urandom);
            rq[1].push_back({(b == 3), d[b]});
        end
        for (int c = 0; c < 13; c++) begin
            bus.fifo_wfull = (c >= 2 && c <= 6);
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            if (bus.fifo_wfull) begin
                checks++;
                if (bus.fifo_w_en !== 1'b0 || bus.req_ready[1] !== 1'b0 || bus.grant_active !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold_cycle%0d wen=%b ready1=%b active=%b required 0,0,1",
                             c, bus.fifo_w_en, bus.req_ready[1], bus.grant_active);
                end
            end
            advance();
        end
        bus.fifo_wfull = 1'b0;
        checks++;
        if (wlog.size() != 4 || wlog[0] !== mkwd(1, d[0]) || wlog[1] !== mkwd(1, d[1])
            || wlog[2] !== mkwd(1, d[2]) || wlog[3] !== mkwd(1, d[3])) begin
            errors++;
            $display("FAIL bp_data got=%p required=%h,%h,%h,%h", wlog, d[0], d[1], d[2], d[3]);
        end
    endtask

    task automatic test_abandon();
        logic prev;
        int n3;
        clear(); do_reset();
        en = 4'b1000;
        rq[3].push_back({1'b0, 8'h33});
        rq[0].push_back({1'b0, 8'h01});
        rq[0].push_back({1'b1, 8'h02});
        prev = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) en[0] = 1'b1;
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abandon_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            if (bus.grant_active && !prev) gq.push_back(int'(bus.grant_id));
            prev = bus.grant_active;
            advance();
        end
        n3 = 0;
        foreach (wsrc[k]) if (wsrc[k] == 3) n3++;
        checks++;
        if (gq.size() != 2 || gq[0] != 3 || gq[1] != 0 || n3 != 1 || wlog.size() != 3) begin
            errors++;
            $display("FAIL abandon_seq grants=%p writes3=%0d total=%0d required grants=3,0 writes3=1 total=3",
                     gq, n3, wlog.size());
        end
    endtask

    task automatic test_reset_mid();
        clear(); do_reset();
        en = '1;
        for (int i = 0; i < NREQ; i++)
            repeat (6) rq[i].push_back({1'b0, DWIDTH'($urandom)});
        for (int c = 0; c < 6; c++) begin
            rst = (c == 2);
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            if (c == 2) begin
                checks++;
                if (bus.fifo_w_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_no_write wen=%b required=0", bus.fifo_w_en);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.grant_active !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_drop active=%b required=0", bus.grant_active);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.grant_active !== 1'b1 || bus.grant_id !== IDW'(0)) begin
                    errors++;
                    $display("FAIL rstmid_regrant active=%b id=%0d required 1,0",
                             bus.grant_active, bus.grant_id);
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_srcid();
        logic [WDW-1:0] want;
`ifdef FIFO_ARB_SRCID_EN
        want = 10'b10_1010_0101;
`else
        want = 8'hA5;
`endif
        clear(); do_reset();
        en = 4'b0100;
        rq[2].push_back({1'b1, 8'hA5});
        for (int c = 0; c < 4; c++) begin
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL srcid_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (wlog.size() != 1 || wlog[0] !== want) begin
            errors++;
            $display("FAIL srcid_wdata got=%p required=%b", wlog, want);
        end
    endtask

    task automatic test_random();
        clear(); do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) == 0 && rq[i].size() < 8)
                    rq[i].push_back({($urandom_range(0, 3) == 0), DWIDTH'($urandom)});
                en[i] = ($urandom_range(0, 9) != 0);
            end
            bus.fifo_wfull = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            drive(); #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d obs=%h required=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        rst = 1'b0;
        bus.fifo_wfull = 1'b0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_last   = '0;
        bus.req_data   = '0;
        bus.fifo_wfull = 1'b0;
        en = '0;
        m_busy = 0; m_gid = 0; m_last = NREQ - 1; m_beats = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_last();
        test_backpressure();
        test_abandon();
        test_reset_mid();
        test_srcid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
